// File: rtl/lgn_infer_ctrl.sv
// rtl/lgn_infer_ctrl.sv - load/settle/score sequencer for the logic-gate-network MNIST datapath
module lgn_infer_ctrl #(
    parameter int INPUTS        = 256,
    parameter int CLASSES       = 10,
    parameter int GROUP         = 400,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    output logic                       in_ready,
    output logic                       x_shift_en,
    output logic [7:0]                 x_byte,
    input  logic [CLASSES*GROUP-1:0]   net_y,
    output logic                       busy,
    output logic                       done,
    output logic [3:0]                 class_out,
    output logic [$clog2(GROUP):0]     score_out
);

    localparam int NB  = INPUTS / 8;
    localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW  = (CLASSES > 1) ? $clog2(CLASSES) : 1;
    localparam int SW  = $clog2(GROUP) + 1;
    localparam int STW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [BW-1:0]  LAST_BYTE   = BW'(NB - 1);
    localparam logic [CW-1:0]  LAST_CLS    = CW'(CLASSES - 1);
    localparam logic [STW-1:0] LAST_SETTLE = STW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SCORE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t          state, state_nx;
    logic [BW-1:0]   byte_cnt;
    logic [STW-1:0]  settle_cnt;
    logic [CW-1:0]   cls;
    logic [CW-1:0]   best_idx;
    logic [SW-1:0]   best_score;

    logic            hs;
    logic [GROUP-1:0] slice;
    logic [SW-1:0]   pop;
    logic            take;
    logic [CW-1:0]   upd_idx;
    logic [SW-1:0]   upd_score;

    assign in_ready   = (state == ST_LOAD);
    assign hs         = in_valid & in_ready;
    assign x_shift_en = hs;
    assign x_byte     = in_data;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (start) state_nx = ST_LOAD;
            ST_LOAD:   if (hs && byte_cnt == LAST_BYTE)
                           state_nx = (SETTLE_CYCLES == 0) ? ST_SCORE : ST_SETTLE;
            ST_SETTLE: if (settle_cnt == LAST_SETTLE) state_nx = ST_SCORE;
            ST_SCORE:  if (cls == LAST_CLS) state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Mux the current class slice out of the flat net output vector.
    always_comb begin
        slice = '0;
        for (int k = 0; k < CLASSES; k++) begin
            if (cls == CW'(k)) slice = net_y[k*GROUP +: GROUP];
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < GROUP; i++) begin
            pop = pop + SW'(slice[i]);
        end
    end

    // Strict compare keeps the lower index on ties; class 0 always seeds the max.
    assign take      = (cls == '0) || (pop > best_score);
    assign upd_idx   = take ? cls : best_idx;
    assign upd_score = take ? pop : best_score;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            byte_cnt   <= '0;
            settle_cnt <= '0;
            cls        <= '0;
            best_idx   <= '0;
            best_score <= '0;
            class_out  <= '0;
            score_out  <= '0;
        end else begin
            state <= state_nx;

            if (state == ST_IDLE && start) begin
                byte_cnt <= '0;
            end else if (hs) begin
                byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + BW'(1);
            end

            if (state == ST_SETTLE) settle_cnt <= settle_cnt + STW'(1);
            else                    settle_cnt <= '0;

            if (state == ST_SCORE) begin
                cls        <= (cls == LAST_CLS) ? '0 : cls + CW'(1);
                best_idx   <= upd_idx;
                best_score <= upd_score;
            end else begin
                cls        <= '0;
                best_idx   <= '0;
                best_score <= '0;
            end

            // Capture on the edge into DONE so the result is valid alongside done.
            if (state == ST_SCORE && cls == LAST_CLS) begin
                class_out <= 4'(upd_idx);
                score_out <= upd_score;
            end
        end
    end

endmodule
